ahb_uart_lite: RTL
==================

# ahb_uart_lite

AHB-Lite slave UART that sits downstream of the CPU bus arbiter's AHB master port and serves as the system console. It exposes a 4-word register window (DATA, STATUS, CTRL, reserved), buffers transmit and receive bytes in small FIFOs, and serializes 8N1 frames on `txd`/`rxd` at a fixed clocks-per-bit rate. It always completes transfers with zero wait states and OKAY responses.

## Interface
- `CLK_DIV`, 868: clocks per serial bit. Legal range is 16 or more.
- `FIFO_DEPTH`, 8: entries in each of the TX and RX FIFOs. Must be a power of 2 and at least 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `hsel`  in  1  slave select from the address decoder.
- `htrans`  in  2  AHB transfer type; bit1=1 means NONSEQ/SEQ.
- `hsize`  in  3  transfer size (0 byte, 1 half, 2 word).
- `haddr`  in  32  address; only `[3:0]` is decoded.
- `hwrite`  in  1  1 = write.
- `hwdata`  in  32  write data, valid in the data phase.
- `hready`  in  1  bus ready; tie to `hreadyout` in a single-slave system.
- `hrdata`  out  32  read data, valid in the data phase.
- `hreadyout`  out  1  always 1.
- `hresp`  out  1  always 0 (OKAY).
- `rxd`  in  1  serial input; asynchronous, idle high.
- `txd`  out  1  serial output; idle high.
- `irq`  out  1  level interrupt.

## Operation
- **Address phase capture:** when `hsel & htrans[1] & hready`, register `haddr[3:2]`, `hwrite`, and the lane-0 flag. Lane 0 is covered when `haddr[1:0]==0` (any size). Otherwise the data phase is idle.
- **Register map (offset):**
  - 0x0 DATA. A write with lane 0 pushes `hwdata[7:0]` into the TX FIFO; if TX is full, the byte is dropped silently. A read returns `{24'b0, rx_head}` and pops RX; if RX is empty, it returns 0 and does not pop.
  - 0x4 STATUS (read-only). Bit0 = rx_valid (RX not empty). Bit1 = tx_full. Bit2 = tx_idle (TX FIFO empty and TX FSM in IDLE). Bit3 = overrun (sticky). Bit4 = frame_err (sticky). Reading STATUS clears bits 3 and 4 at the end of the data phase.
  - 0x8 CTRL (R/W). Bit0 = rx_irq_en, bit1 = tx_irq_en. Other bits read 0.
  - 0xC reserved. Reads 0; writes ignored.
- **irq:** registered `(rx_irq_en & rx_valid) | (tx_irq_en & tx FIFO empty)`.
- **TX FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is not empty; this pops the head into the shifter.
  - START drives 0 for CLK_DIV cycles.
  - DATA drives 8 bits LSB first, CLK_DIV cycles each.
  - STOP drives 1 for CLK_DIV cycles. At the end of STOP: if the FIFO is not empty, pop and go to START directly (zero-gap frames); otherwise go to IDLE.
- **RX path:** `rxd` passes through a 2-flop synchronizer. RX FSM states are IDLE, START, DATA, STOP.
  - IDLE → START on a synchronized 1→0 edge.
  - START waits CLK_DIV/2 cycles. If the line is still 0, go to DATA; otherwise it is a glitch and the FSM returns to IDLE.
  - DATA samples every CLK_DIV cycles, 8 bits LSB first.
  - STOP samples after CLK_DIV cycles. If the sample is 1, push the byte into RX; if RX is full, drop the byte and set overrun. If the sample is 0, discard the byte and set frame_err. Either way, return to IDLE.
- **FIFOs:** pointers are log2(FIFO_DEPTH)+1 bits wide, with wrap-around by natural overflow. Full means the low bits are equal and the MSBs differ. Push and pop in the same cycle are both performed and the count is unchanged. A pop on empty or a push on full has no effect.
- **Simultaneous set and clear:** if a sticky bit is set and cleared in the same cycle, set wins.

## Timing
- **Reset values:** `hrdata`=0, `hreadyout`=1, `hresp`=0, `txd`=1, `irq`=0. Also reset: CTRL=0, FIFOs empty, sticky bits 0, both FSMs IDLE, synchronizer flops 1.
- **Reset mid-frame:** `txd` returns to 1 immediately (asynchronous reset); a partial RX byte is lost.
- **Reads:** `hrdata` is driven combinationally from the captured address and current state during the data phase. It is 0 outside a read data phase.
- **Write visibility:** a DATA write in data-phase cycle N makes the entry visible at N+1. If TX was IDLE, it pops at N+1 and `txd` falls at N+2.
- **Frame length:** exactly 10×CLK_DIV cycles, measured from the `txd` fall to the end of the stop bit.
- **RX latency:** a byte is pushed 2 (sync) + CLK_DIV/2 + 9×CLK_DIV cycles after the `rxd` fall (±1). rx_valid rises the next cycle.
- **irq** lags its condition by 1 cycle.
- **Back-to-back accesses:** pipelined transfers are accepted every cycle. A DATA read followed immediately by another DATA read returns successive RX entries.

## Test plan
- **Reset check.** Assert `rst_n`=0 asynchronously mid-cycle → `txd`=1, `irq`=0, `hreadyout`=1; STATUS reads 0x4.
- **Single TX byte.** CLK_DIV=16: write 0xA5 to 0x0 → `txd` pattern is 0, then 1,0,1,0,0,1,0,1, then 1, each held 16 cycles; STATUS bit2 returns to 1 after the stop bit.
- **TX overflow.** CLK_DIV=16, FIFO_DEPTH=8: burst-write 10 bytes 0x00–0x09 back-to-back → bytes 0x00–0x08 are transmitted (1 in the shifter plus 8 in the FIFO), 0x09 is dropped, and frames have zero gap.
- **RX receive.** Drive frame 0x3C on `rxd` → STATUS reads 0x05; a DATA read returns 0x0000003C; STATUS then reads 0x04.
- **RX overrun and framing error.** Send 9 frames without reading → STATUS bit3=1 and the FIFO holds the first 8 bytes; read STATUS → bit3 clears. Send a frame with stop bit 0 → bit4=1 and no push.
- **Interrupts.** Write CTRL=0x1, receive one byte → `irq`=1; read DATA → `irq`=0. Then write CTRL=0x2 with TX empty → `irq`=1 one cycle after the write.

Source files
------------

// File: rtl/ahb_uart_lite.sv
// ahb_uart_lite: AHB-Lite console UART. Zero-wait-state register window
// (DATA, STATUS, CTRL, reserved), byte FIFOs on both directions and a fixed
// CLK_DIV clocks-per-bit 8N1 serializer/deserializer.
//
// TX and RX FSMs share one encoding:
//   state   | meaning
//   S_IDLE  | line idle (TX: waiting for FIFO data, RX: waiting for falling edge)
//   S_START | start bit (TX: driving 0, RX: half-bit check for a real start)
//   S_DATA  | 8 data bits, LSB first, one bit per CLK_DIV cycles
//   S_STOP  | stop bit (TX: driving 1, RX: sampling and pushing the byte)

// Byte FIFO with one extra pointer bit to tell full from empty.
module ahb_uart_lite_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointers wrap by natural overflow of the extra bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

module ahb_uart_lite #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp,
    input  logic        rxd,
    output logic        txd,
    output logic        irq
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Bus data-phase state.
    logic       dp_valid;
    logic       dp_write;
    logic       dp_lane0;
    logic [1:0] dp_addr;
    logic       rd_phase;
    logic       wr_done;
    logic       rd_done;

    // Register state.
    logic [1:0] ctrl;
    logic       overrun;
    logic       frame_err;

    // FIFO hookup.
    logic       tx_push;
    logic       tx_pop;
    logic [7:0] tx_head;
    logic       tx_empty;
    logic       tx_full;
    logic       rx_push;
    logic       rx_pop;
    logic [7:0] rx_head;
    logic       rx_empty;
    logic       rx_full;

    // TX engine.
    logic [1:0]    tx_state;
    logic [CW-1:0] tx_cnt;
    logic [7:0]    tx_sh;
    logic [2:0]    tx_bit;
    logic          tx_idle;

    // RX engine.
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [7:0]    rx_sh;
    logic [2:0]    rx_bit;
    logic          rx_stop_end;
    logic          ferr_set;
    logic          ovr_set;

    logic          stat_rd;
    logic          unused_ok;

    assign hreadyout = 1'b1;
    assign hresp     = 1'b0;
    // Only lane 0 and the word offset are decoded; the rest is don't-care.
    assign unused_ok = ^{hsize, haddr[31:4], hwdata[31:8]};

    // Capture the address phase of every accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_lane0 <= 1'b0;
            dp_addr  <= 2'd0;
        end else if (hready) begin
            dp_valid <= hsel & htrans[1];
            dp_write <= hwrite;
            dp_lane0 <= (haddr[1:0] == 2'b00);
            dp_addr  <= haddr[3:2];
        end
    end

    assign rd_phase = dp_valid & ~dp_write;
    assign wr_done  = dp_valid & dp_write & hready;
    assign rd_done  = rd_phase & hready;
    assign tx_push  = wr_done & dp_lane0 & (dp_addr == 2'd0);
    assign rx_pop   = rd_done & (dp_addr == 2'd0);
    assign stat_rd  = rd_done & (dp_addr == 2'd1);
    assign tx_idle  = tx_empty & (tx_state == S_IDLE);

    // Read mux; zero outside a read data phase.
    always_comb begin
        hrdata = 32'h0;
        if (rd_phase) begin
            case (dp_addr)
                2'd0:    hrdata[7:0] = rx_empty ? 8'h00 : rx_head;
                2'd1:    hrdata[4:0] = {frame_err, overrun, tx_idle, tx_full, ~rx_empty};
                2'd2:    hrdata[1:0] = ctrl;
                default: hrdata = 32'h0;
            endcase
        end
    end

    // CTRL register, sticky status bits (set beats clear) and the irq flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl      <= 2'b00;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr_done && dp_lane0 && dp_addr == 2'd2) ctrl <= hwdata[1:0];
            if (ovr_set)       overrun <= 1'b1;
            else if (stat_rd)  overrun <= 1'b0;
            if (ferr_set)      frame_err <= 1'b1;
            else if (stat_rd)  frame_err <= 1'b0;
            irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty);
        end
    end

    ahb_uart_lite_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .din   (hwdata[7:0]),
        .pop   (tx_pop),
        .head  (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    ahb_uart_lite_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .din   (rx_sh),
        .pop   (rx_pop),
        .head  (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

    // A new byte is loaded from IDLE or straight out of a finished stop bit.
    assign tx_pop = ~tx_empty & ((tx_state == S_IDLE) ||
                                 (tx_state == S_STOP && tx_cnt == '0));

    // TX serializer: start, 8 data bits LSB first, stop; txd is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_sh    <= 8'h00;
            tx_bit   <= 3'd0;
            txd      <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (!tx_empty) begin
                        tx_state <= S_START;
                        tx_sh    <= tx_head;
                        tx_cnt   <= BIT_LAST;
                        txd      <= 1'b0;
                    end
                end
                S_START: begin
                    if (tx_cnt == '0) begin
                        tx_state <= S_DATA;
                        txd      <= tx_sh[0];
                        tx_sh    <= {1'b0, tx_sh[7:1]};
                        tx_bit   <= 3'd0;
                        tx_cnt   <= BIT_LAST;
                    end else begin
                        tx_cnt <= tx_cnt - CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= BIT_LAST;
                        if (tx_bit == 3'd7) begin
                            tx_state <= S_STOP;
                            txd      <= 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            txd    <= tx_sh[0];
                            tx_sh  <= {1'b0, tx_sh[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt - CNT_ONE;
                    end
                end
                default: begin
                    if (tx_cnt == '0) begin
                        if (!tx_empty) begin
                            tx_state <= S_START;
                            tx_sh    <= tx_head;
                            tx_cnt   <= BIT_LAST;
                            txd      <= 1'b0;
                        end else begin
                            tx_state <= S_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Two-flop synchronizer on rxd plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_stop_end = (rx_state == S_STOP) && (rx_cnt == '0);
    assign rx_push     = rx_stop_end & rx_sync;
    assign ovr_set     = rx_push & rx_full;
    assign ferr_set    = rx_stop_end & ~rx_sync;

    // RX deserializer: half-bit start check, then one sample per bit time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_sh    <= 8'h00;
            rx_bit   <= 3'd0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= S_START;
                        rx_cnt   <= HALF_LAST;
                    end
                end
                S_START: begin
                    if (rx_cnt == '0) begin
                        rx_state <= rx_sync ? S_IDLE : S_DATA;
                        rx_cnt   <= BIT_LAST;
                        rx_bit   <= 3'd0;
                    end else begin
                        rx_cnt <= rx_cnt - CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_sh  <= {rx_sync, rx_sh[7:1]};
                        rx_cnt <= BIT_LAST;
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - CNT_ONE;
                    end
                end
                default: begin
                    if (rx_cnt == '0) rx_state <= S_IDLE;
                    else              rx_cnt   <= rx_cnt - CNT_ONE;
                end
            endcase
        end
    end
endmodule
